// File: rtl/iob_neg2pos_skid_pkg.sv
// Shared occupancy encoding and control-flag payload for the neg-to-pos skid buffer.
package iob_neg2pos_skid_pkg;

  localparam int unsigned LEVEL_W = 2;

  // Occupancy doubles as the state: number of words held (head, then skid).
  typedef enum logic [LEVEL_W-1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } level_e;

  // Registered control flags, kept together so they update in one register.
  typedef struct packed {
    logic               in_ready;
    logic               out_valid;
    logic [LEVEL_W-1:0] level;
  } flags_t;

  localparam int unsigned FLAGS_W = $bits(flags_t);

  localparam flags_t FLAGS_RST = '{
    in_ready:  1'b1,
    out_valid: 1'b0,
    level:     LEVEL_W'(LVL_EMPTY)
  };

endpackage

// File: rtl/iob_neg2pos_skid_reg_re.sv
// Module: iob_reg_re
// Posedge register with synchronous active-high reset and load enable.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous reset, active-high, overrides en_i
//   en_i   - load enable
//   data_i - next value
//   data_o - registered value
module iob_reg_re #(
  parameter int unsigned        DATA_W  = 1,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= RST_VAL;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_neg2pos_skid.sv
// Module: iob_neg2pos_skid
// Captures a negedge-launched valid/data stream on the rising edge and hands it to
// posedge logic through a 2-entry skid buffer (head + skid) with valid/ready flow
// control. Sustains one word per cycle; every output comes straight from a flop.
// Ports:
//   clk_i       - single clock, all updates on posedge
//   rst_i       - synchronous reset, active-high, overrides cke_i
//   cke_i       - clock enable, 0 holds all state
//   in_valid_i  - producer word valid (negedge launched)
//   in_data_i   - producer word (negedge launched)
//   in_ready_o  - buffer can accept (registered)
//   out_valid_o - word available on data_o (registered)
//   out_ready_i - consumer accepts
//   data_o      - head word (registered)
//   level_o     - occupancy 0..2
module iob_neg2pos_skid
  import iob_neg2pos_skid_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        level_o
);

  flags_t              flags_q;
  flags_t              flags_d;
  logic [DATA_W-1:0]   head_q;
  logic [DATA_W-1:0]   head_d;
  logic [DATA_W-1:0]   skid_q;
  logic                head_en;
  logic                skid_en;
  logic                push;
  logic                pop;
  logic [LEVEL_W-1:0]  lvl_n;

  // Handshakes only use registered ready/valid, so no input reaches an output.
  assign push = in_valid_i & flags_q.in_ready & cke_i;
  assign pop  = flags_q.out_valid & out_ready_i & cke_i;

  // Next occupancy and which data register loads.
  always_comb begin
    flags_d = flags_q;
    lvl_n   = flags_q.level;
    head_en = 1'b0;
    skid_en = 1'b0;
    head_d  = in_data_i;
    case (flags_q.level)
      LEVEL_W'(LVL_EMPTY): begin
        if (push) begin
          lvl_n   = LEVEL_W'(LVL_ONE);
          head_en = 1'b1;
        end
      end
      LEVEL_W'(LVL_ONE): begin
        if (push && pop) begin
          head_en = 1'b1;
        end else if (push) begin
          lvl_n   = LEVEL_W'(LVL_FULL);
          skid_en = 1'b1;
        end else if (pop) begin
          lvl_n   = LEVEL_W'(LVL_EMPTY);
        end
      end
      LEVEL_W'(LVL_FULL): begin
        // in_ready is low here, so a pop is the only possible event.
        if (pop) begin
          lvl_n   = LEVEL_W'(LVL_ONE);
          head_en = 1'b1;
          head_d  = skid_q;
        end
      end
      default: ;
    endcase
    flags_d.level     = lvl_n;
    flags_d.in_ready  = (lvl_n != LEVEL_W'(LVL_FULL));
    flags_d.out_valid = (lvl_n != LEVEL_W'(LVL_EMPTY));
  end

  iob_reg_re #(
    .DATA_W  (FLAGS_W),
    .RST_VAL (FLAGS_W'(FLAGS_RST))
  ) u_flags_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (cke_i),
    .data_i (flags_d),
    .data_o (flags_q)
  );

  iob_reg_re #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_head_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (head_en),
    .data_i (head_d),
    .data_o (head_q)
  );

  iob_reg_re #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_skid_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (skid_en),
    .data_i (in_data_i),
    .data_o (skid_q)
  );

  assign in_ready_o  = flags_q.in_ready;
  assign out_valid_o = flags_q.out_valid;
  assign data_o      = head_q;
  assign level_o     = flags_q.level;

endmodule

// File: tb/tb_iob_neg2pos_skid.sv
module tb_iob_neg2pos_skid;

  localparam int unsigned DATA_W  = 8;
  localparam logic [7:0]  RST_VAL = 8'hA5;
  localparam int unsigned N_RAND  = 10000;
  localparam int unsigned MAX_CYC = 60000;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cke_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        level_o;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain FIFO of capacity 2 plus the flags it implies.
  logic [7:0] q[$];
  logic       m_ready;
  logic       m_valid;
  logic       m_after_rst;
  int         npop;

  iob_neg2pos_skid #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cke_i       (cke_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .level_o     (level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("level", 32'(level_o), 32'(q.size()));
    chk("in_ready", 32'(in_ready_o), 32'(m_ready));
    chk("out_valid", 32'(out_valid_o), 32'(m_valid));
    chk("ready_at_full", 32'(in_ready_o & (level_o == 2'd2)), 32'd0);
    if (m_valid) chk("data", 32'(data_o), 32'(q[0]));
    else if (m_after_rst) chk("data_rst", 32'(data_o), 32'(RST_VAL));
  endtask

  // Called at a negedge: drive inputs, check outputs have not reacted, then clock.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r,
                       input logic c, input logic rs);
    logic push;
    logic pop;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    cke_i       = c;
    rst_i       = rs;
    #1;
    check_outputs();
    @(posedge clk_i);
    if (rs) begin
      q.delete();
      m_after_rst = 1'b1;
    end else begin
      push = v & m_ready & c;
      pop  = m_valid & r & c;
      if (pop) begin
        void'(q.pop_front());
        npop++;
      end
      if (push) q.push_back(d);
      if (push || pop) m_after_rst = 1'b0;
    end
    m_ready = (q.size() < 2);
    m_valid = (q.size() != 0);
    @(negedge clk_i);
  endtask

  initial begin
    int cyc;
    npop        = 0;
    rst_i       = 1'b1;
    cke_i       = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;

    // 1: reset for two cycles, with cke low to show reset wins
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    q.delete();
    m_ready     = 1'b1;
    m_valid     = 1'b0;
    m_after_rst = 1'b1;
    chk("rst_data", 32'(data_o), 32'h0000_00A5);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_level", 32'(level_o), 32'd0);

    // 2: streaming with consumer always ready
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // 3: backpressure fills both entries, third word held off until release
    cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // 4: clock enable low while valid and ready are both high
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h79, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // 5: reset while full discards both words
    cycle(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // 6: random valid/ready/cke traffic against the FIFO model
    npop = 0;
    cyc  = 0;
    while (npop < N_RAND && cyc < MAX_CYC) begin
      cycle(($urandom_range(99) < 75), 8'($urandom), ($urandom_range(99) < 75),
            ($urandom_range(99) < 92), ($urandom_range(4999) == 0));
      cyc++;
    end
    chk("rand_words_done", 32'(npop >= N_RAND), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
